vending_machine_gen: RTL and testbench

Parametrised vending controller, successor to the fixed 3-state vending FSM. Accumulates credit from three coin denominations and vends at a configurable price. Returns change or refunds as a serial coin stream using a valid/ready handshake. Sits between the coin acceptor front-end and the dispense/coin-return actuators.

---
 rtl/vending_machine_gen.sv | 163 ++++++++++++++++
 tb/tb_vending_machine_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_gen.sv
// Parametrised vending controller: accumulates coin credit, vends at PRICE and
// returns change/refunds as a valid/ready coin stream. Optional: VENDING_TIMEOUT_EN.
module vending_machine_gen #(
  parameter int CREDIT_W    = 8,
  parameter int PRICE       = 15,
  parameter int COIN1_VAL   = 5,
  parameter int COIN2_VAL   = 10,
  parameter int COIN3_VAL   = 25,
  parameter int MAX_CREDIT  = 100,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                change_ready,
  output logic                vend,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0] MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0] COIN1_X = (CREDIT_W+1)'(COIN1_VAL);
  localparam logic [CREDIT_W:0] COIN2_X = (CREDIT_W+1)'(COIN2_VAL);
  localparam logic [CREDIT_W:0] COIN3_X = (CREDIT_W+1)'(COIN3_VAL);

  function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] c);
    case (c)
      2'b01:   return COIN1_X;
      2'b10:   return COIN2_X;
      2'b11:   return COIN3_X;
      default: return '0;
    endcase
  endfunction

  // Largest denomination not exceeding the remaining credit.
  function automatic logic [1:0] greedy(input logic [CREDIT_W-1:0] cr);
    logic [1:0]        best;
    logic [CREDIT_W:0] best_val;
    logic [CREDIT_W:0] v;
    best     = 2'b00;
    best_val = '0;
    for (int i = 1; i < 4; i++) begin
      v = coin_value(2'(i));
      if (v <= {1'b0, cr} && v > best_val) begin
        best     = 2'(i);
        best_val = v;
      end
    end
    return best;
  endfunction

  state_t                state_reg, state_next;
  logic [CREDIT_W-1:0]   credit_reg, credit_next;
  logic                  vend_reg, coin_reject_reg, change_valid_reg, busy_reg;
  logic [1:0]            change_coin_reg;
  logic                  reject_next;
  logic                  accepted;
  logic                  offered;
  logic                  timeout_hit;
  logic [CREDIT_W:0]     sum;
  logic [CREDIT_W:0]     diff;

  assign offered = coin_valid && (coin != 2'b00);

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    reject_next = 1'b0;
    accepted    = 1'b0;
    sum         = {1'b0, credit_reg} + coin_value(coin);
    diff        = {1'b0, credit_reg};
    case (state_reg)
      IDLE, COLLECT: begin
        if (state_reg == COLLECT && cancel && credit_reg != '0) begin
          // Cancel takes priority; a coin offered alongside it bounces.
          state_next  = CHANGE;
          reject_next = offered;
        end else if (offered) begin
          if (sum <= MAX_X) begin
            credit_next = sum[CREDIT_W-1:0];
            accepted    = 1'b1;
            state_next  = (sum >= PRICE_X) ? VEND : COLLECT;
          end else begin
            reject_next = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next = CHANGE;
        end
      end
      VEND: begin
        reject_next = offered;
        diff        = {1'b0, credit_reg} - PRICE_X;
        credit_next = diff[CREDIT_W-1:0];
        state_next  = (credit_next != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_next = offered;
        if (change_valid_reg && change_ready) begin
          diff        = {1'b0, credit_reg} - coin_value(change_coin_reg);
          credit_next = diff[CREDIT_W-1:0];
          if (credit_next == '0)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef VENDING_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_reg;

  assign timeout_hit = (state_reg == COLLECT) && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || accepted || state_next != COLLECT)
      tmo_cnt_reg <= '0;
    else if (state_reg == COLLECT)
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
  end
`else
  logic unused_tmo;
  assign timeout_hit = 1'b0;
  assign unused_tmo  = accepted ^ (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      credit_reg       <= '0;
      vend_reg         <= 1'b0;
      coin_reject_reg  <= 1'b0;
      change_valid_reg <= 1'b0;
      change_coin_reg  <= 2'b00;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      credit_reg       <= credit_next;
      vend_reg         <= (state_next == VEND);
      coin_reject_reg  <= reject_next;
      change_valid_reg <= (state_next == CHANGE);
      // Derived from credit_next, so it stays put while the actuator stalls.
      change_coin_reg  <= (state_next == CHANGE) ? greedy(credit_next) : 2'b00;
      busy_reg         <= (state_next == VEND) || (state_next == CHANGE);
    end
  end

  assign vend         = vend_reg;
  assign coin_reject  = coin_reject_reg;
  assign change_valid = change_valid_reg;
  assign change_coin  = change_coin_reg;
  assign credit       = credit_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_vending_machine_gen.sv
// Directed, table-driven bench for vending_machine_gen (default build and
// VENDING_TIMEOUT_EN build), plus hand-written multi-cycle sequences.
module tb_vending_machine_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid, cancel, change_ready;
  logic [1:0] coin;
  logic       vend, coin_reject, change_valid, busy;
  logic [1:0] change_coin;
  logic [7:0] credit;

  logic       c_coin_valid, c_cancel, c_change_ready;
  logic [1:0] c_coin;
  logic       c_vend, c_coin_reject, c_change_valid, c_busy;
  logic [1:0] c_change_coin;
  logic [7:0] c_credit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vending_machine_gen #(.TIMEOUT_CYC(8)) u_dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
    .change_ready(change_ready), .vend(vend), .coin_reject(coin_reject),
    .change_valid(change_valid), .change_coin(change_coin), .credit(credit), .busy(busy)
  );

  // Low ceiling relative to price so the overflow path is reachable.
  vending_machine_gen #(.PRICE(30), .MAX_CREDIT(20)) u_cap (
    .clk(clk), .rst(rst), .coin_valid(c_coin_valid), .coin(c_coin), .cancel(c_cancel),
    .change_ready(c_change_ready), .vend(c_vend), .coin_reject(c_coin_reject),
    .change_valid(c_change_valid), .change_coin(c_change_coin), .credit(c_credit), .busy(c_busy)
  );

  // Packed output word: {vend, coin_reject, change_valid, change_coin, busy, credit}
  typedef struct {
    logic       cv;
    logic [1:0] coin;
    logic       cancel;
    logic       ready;
    logic [13:0] exp;
  } vec_t;

  function automatic logic [13:0] pk(logic vd, logic rj, logic chv, logic [1:0] cc,
                                     logic bz, logic [7:0] cr);
    return {vd, rj, chv, cc, bz, cr};
  endfunction

  function automatic vec_t mk(logic cv, logic [1:0] c, logic can, logic rdy, logic vd,
                              logic rj, logic chv, logic [1:0] cc, logic bz, logic [7:0] cr);
    vec_t v;
    v.cv = cv; v.coin = c; v.cancel = can; v.ready = rdy;
    v.exp = pk(vd, rj, chv, cc, bz, cr);
    return v;
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got vend=%b rej=%b cv=%b cc=%b busy=%b credit=%0d want vend=%b rej=%b cv=%b cc=%b busy=%b credit=%0d",
               name, act[13], act[12], act[11], act[10:9], act[8], act[7:0],
               exp[13], exp[12], exp[11], exp[10:9], exp[8], exp[7:0]);
    end else begin
      $display("ok   %s credit=%0d", name, act[7:0]);
    end
  endtask

  function automatic logic [13:0] dut_out();
    return pk(vend, coin_reject, change_valid, change_coin, busy, credit);
  endfunction

  function automatic logic [13:0] cap_out();
    return pk(c_vend, c_coin_reject, c_change_valid, c_change_coin, c_busy, c_credit);
  endfunction

  task automatic drive(logic cv, logic [1:0] c, logic can, logic rdy);
    coin_valid = cv; coin = c; cancel = can; change_ready = rdy;
  endtask

  task automatic cdrive(logic cv, logic [1:0] c, logic can, logic rdy);
    c_coin_valid = cv; c_coin = c; c_cancel = can; c_change_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[26];

  initial begin
    // Test 1: 5 + 10 -> exact price
    vecs[0]  = mk(1, 2'b01, 0, 1,  0, 0, 0, 2'b00, 0, 8'd5);
    vecs[1]  = mk(1, 2'b10, 0, 1,  1, 0, 0, 2'b00, 1, 8'd15);
    vecs[2]  = mk(0, 2'b00, 0, 1,  0, 0, 0, 2'b00, 0, 8'd0);
    // Test 2: 25 -> vend, change 10
    vecs[3]  = mk(1, 2'b11, 0, 1,  1, 0, 0, 2'b00, 1, 8'd25);
    vecs[4]  = mk(0, 2'b00, 0, 1,  0, 0, 1, 2'b10, 1, 8'd10);
    vecs[5]  = mk(0, 2'b00, 0, 1,  0, 0, 0, 2'b00, 0, 8'd0);
    // Test 3: 10 + 10 -> vend, change 5
    vecs[6]  = mk(1, 2'b10, 0, 1,  0, 0, 0, 2'b00, 0, 8'd10);
    vecs[7]  = mk(1, 2'b10, 0, 1,  1, 0, 0, 2'b00, 1, 8'd20);
    vecs[8]  = mk(0, 2'b00, 0, 1,  0, 0, 1, 2'b01, 1, 8'd5);
    vecs[9]  = mk(0, 2'b00, 0, 1,  0, 0, 0, 2'b00, 0, 8'd0);
    // Test 4: 5 then cancel with a coin alongside
    vecs[10] = mk(1, 2'b01, 0, 1,  0, 0, 0, 2'b00, 0, 8'd5);
    vecs[11] = mk(1, 2'b01, 1, 1,  0, 1, 1, 2'b01, 1, 8'd5);
    vecs[12] = mk(0, 2'b00, 0, 1,  0, 0, 0, 2'b00, 0, 8'd0);
    // Test 5: 25, actuator stalled, coin offered during CHANGE
    vecs[13] = mk(1, 2'b11, 0, 0,  1, 0, 0, 2'b00, 1, 8'd25);
    vecs[14] = mk(0, 2'b00, 0, 0,  0, 0, 1, 2'b10, 1, 8'd10);
    vecs[15] = mk(1, 2'b01, 0, 0,  0, 1, 1, 2'b10, 1, 8'd10);
    vecs[16] = mk(0, 2'b00, 0, 0,  0, 0, 1, 2'b10, 1, 8'd10);
    vecs[17] = mk(0, 2'b00, 0, 0,  0, 0, 1, 2'b10, 1, 8'd10);
    vecs[18] = mk(0, 2'b00, 0, 1,  0, 0, 0, 2'b00, 0, 8'd0);
    // coin_valid with code 00 is ignored
    vecs[19] = mk(1, 2'b00, 0, 1,  0, 0, 0, 2'b00, 0, 8'd0);
    // 10 + 25 = 35 -> vend, change 20 as 10,10
    vecs[20] = mk(1, 2'b10, 0, 1,  0, 0, 0, 2'b00, 0, 8'd10);
    vecs[21] = mk(1, 2'b11, 0, 1,  1, 0, 0, 2'b00, 1, 8'd35);
    vecs[22] = mk(0, 2'b00, 0, 1,  0, 0, 1, 2'b10, 1, 8'd20);
    vecs[23] = mk(0, 2'b00, 0, 1,  0, 0, 1, 2'b10, 1, 8'd10);
    vecs[24] = mk(0, 2'b00, 0, 1,  0, 0, 0, 2'b00, 0, 8'd0);
    // cancel with zero credit is ignored
    vecs[25] = mk(0, 2'b00, 1, 1,  0, 0, 0, 2'b00, 0, 8'd0);

    rst = 1'b1;
    drive(0, 2'b00, 0, 1);
    cdrive(0, 2'b00, 0, 1);
    tick();
    tick();
    check("reset_dut", dut_out(), 14'd0);
    check("reset_cap", cap_out(), 14'd0);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].cv, vecs[i].coin, vecs[i].cancel, vecs[i].ready);
      tick();
      check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

    // Reset asserted mid-CHANGE discards the pending change.
    drive(1, 2'b11, 0, 0);
    tick();
    drive(0, 2'b00, 0, 0);
    tick();
    check("pre_rst_change", dut_out(), pk(0, 0, 1, 2'b10, 1, 8'd10));
    rst = 1'b1;
    tick();
    check("rst_mid_change", dut_out(), 14'd0);
    rst = 1'b0;
    drive(0, 2'b00, 0, 1);
    tick();
    check("after_rst_idle", dut_out(), 14'd0);

    // Overflow past MAX_CREDIT rejects the coin and holds credit.
    cdrive(1, 2'b10, 0, 1);
    tick();
    check("cap_10", cap_out(), pk(0, 0, 0, 2'b00, 0, 8'd10));
    tick();
    check("cap_20", cap_out(), pk(0, 0, 0, 2'b00, 0, 8'd20));
    cdrive(1, 2'b01, 0, 1);
    tick();
    check("cap_overflow", cap_out(), pk(0, 1, 0, 2'b00, 0, 8'd20));
    cdrive(0, 2'b00, 0, 1);
    tick();
    check("cap_hold", cap_out(), pk(0, 0, 0, 2'b00, 0, 8'd20));
    cdrive(0, 2'b00, 1, 1);
    tick();
    check("cap_cancel", cap_out(), pk(0, 0, 1, 2'b10, 1, 8'd20));
    cdrive(0, 2'b00, 0, 1);
    tick();
    check("cap_refund1", cap_out(), pk(0, 0, 1, 2'b10, 1, 8'd10));
    tick();
    check("cap_refund_done", cap_out(), 14'd0);

`ifdef VENDING_TIMEOUT_EN
    begin
      int waited;
      bit seen;
      seen = 1'b0;
      waited = 0;
      drive(1, 2'b01, 0, 1);
      tick();
      check("tmo_coin", dut_out(), pk(0, 0, 0, 2'b00, 0, 8'd5));
      drive(0, 2'b00, 0, 1);
      for (int n = 1; n <= 20 && !seen; n++) begin
        tick();
        if (change_valid) begin
          seen = 1'b1;
          waited = n;
        end
      end
      checks++;
      if (!seen || waited != 8) begin
        errors++;
        $display("FAIL tmo_delay got seen=%0d cycles=%0d want cycles=8", seen, waited);
      end else begin
        $display("ok   tmo_delay cycles=%0d", waited);
      end
      check("tmo_refund", dut_out(), pk(0, 0, 1, 2'b01, 1, 8'd5));
      tick();
      check("tmo_done", dut_out(), 14'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
